// File: rtl/free_list_pkg.sv
// Shared types and sizing for the physical-register free list.
// Physical registers 0..ARCH_REGS-1 hold the reset architectural mapping,
// so only PR_ENTRIES-ARCH_REGS IDs circulate through the free list.
package free_list_pkg;

  localparam int SS         = 2;   // superscalar width: pop lanes and push lanes
  localparam int PR_ENTRIES = 64;  // physical register count
  localparam int ARCH_REGS  = 32;  // architectural register count

  // FL_DEPTH must be a power of two (pointers wrap by truncation) and >= SS.
  localparam int FL_DEPTH   = PR_ENTRIES - ARCH_REGS;
  localparam int PR_W       = $clog2(PR_ENTRIES);
  localparam int IDX_W      = $clog2(FL_DEPTH);
  localparam int CNT_W      = $clog2(FL_DEPTH + 1);

  typedef logic [PR_W-1:0]  pr_id_t;   // physical register ID
  typedef logic [IDX_W-1:0] fl_idx_t;  // head/tail index into storage
  typedef logic [CNT_W-1:0] fl_cnt_t;  // occupancy, 0..FL_DEPTH inclusive
  typedef logic [CNT_W:0]   fl_sum_t;  // one extra bit to detect overflow

  // One commit-path return lane.
  typedef struct packed {
    logic   valid;
    pr_id_t id;
  } free_list_push_t;

endpackage

// File: rtl/free_list.sv
// Purpose: circular FIFO of free physical register IDs; pops SS per cycle, accepts up to SS returns.
// Latency: head lanes are combinational from storage; pushes become visible the cycle after.
// Backpressure: avail gates pops (all-or-nothing); an overflowing push is dropped whole, errors are sticky.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pop             dispatch takes the SS head entries (honoured only when avail)
//   free_list_regs  lane i = storage[head+i]; lanes at or past count are stale
//   avail           count >= SS
//   push_valid      per-lane valid for returned IDs from commit
//   push_regs       returned IDs, compacted in ascending lane order at tail
//   count           free entries, 0..FL_DEPTH
//   err_underflow   sticky: pop requested while avail=0
//   err_overflow    sticky: a push would have exceeded FL_DEPTH
module free_list
  import free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pop,
  output pr_id_t [SS-1:0]   free_list_regs,
  output logic              avail,
  input  logic [SS-1:0]     push_valid,
  input  pr_id_t [SS-1:0]   push_regs,
  output fl_cnt_t           count,
  output logic              err_underflow,
  output logic              err_overflow
);

  pr_id_t  storage [FL_DEPTH];
  fl_idx_t head;
  fl_idx_t tail;
  fl_cnt_t count_q;
  logic    err_underflow_q;
  logic    err_overflow_q;

  free_list_push_t [SS-1:0] lanes;
  fl_idx_t [SS-1:0]         wr_idx;
  fl_cnt_t                  npush;
  fl_cnt_t                  count_after_pop;
  fl_sum_t                  count_sum;
  fl_cnt_t                  count_next;
  logic                     pop_ok;
  logic                     push_drop;

  // Bundle the commit lanes.
  always_comb begin
    lanes = '0;
    for (int i = 0; i < SS; i++) begin
      lanes[i].valid = push_valid[i];
      lanes[i].id    = push_regs[i];
    end
  end

  // Read path: no bypass of same-cycle pushes; index wraps by truncation.
  always_comb begin
    free_list_regs = '0;
    for (int i = 0; i < SS; i++) begin
      free_list_regs[i] = storage[head + fl_idx_t'(i)];
    end
  end

  // avail and pop_ok depend only on the pre-edge count.
  assign avail  = (count_q >= fl_cnt_t'(SS));
  assign pop_ok = pop & avail;

  // Lane compaction: each valid lane's slot is tail plus the number of valid
  // lanes below it, so gaps in push_valid never leave holes in storage.
  always_comb begin
    fl_cnt_t run;
    run    = '0;
    wr_idx = '0;
    for (int i = 0; i < SS; i++) begin
      wr_idx[i] = tail + fl_idx_t'(run);
      if (lanes[i].valid) begin
        run = run + fl_cnt_t'(1);
      end
    end
    npush = run;
  end

  // Overflow is judged on the net result so a pop in the same cycle makes
  // room for the returning IDs.
  always_comb begin
    count_after_pop = count_q - (pop_ok ? fl_cnt_t'(SS) : fl_cnt_t'(0));
    count_sum       = {1'b0, count_after_pop} + {1'b0, npush};
    push_drop       = (count_sum > fl_sum_t'(FL_DEPTH));
    count_next      = push_drop ? count_after_pop : count_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        storage[i] <= pr_id_t'(ARCH_REGS + i);
      end
      head            <= '0;
      tail            <= '0;
      count_q         <= fl_cnt_t'(FL_DEPTH);
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      if (pop_ok) begin
        head <= head + fl_idx_t'(SS);
      end
      if (!push_drop) begin
        for (int i = 0; i < SS; i++) begin
          if (lanes[i].valid) begin
            storage[wr_idx[i]] <= lanes[i].id;
          end
        end
        tail <= tail + fl_idx_t'(npush);
      end
      count_q <= count_next;
      if (pop && !avail) begin
        err_underflow_q <= 1'b1;
      end
      if (push_drop) begin
        err_overflow_q <= 1'b1;
      end
    end
  end

  assign count         = count_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: the stimulus process updates a queue-based
// model of the free list and pushes the expected post-edge outputs; the
// monitor pops one expectation per clock edge and compares.
module tb_free_list;
  import free_list_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            pop;
  logic [SS-1:0]   push_valid;
  pr_id_t [SS-1:0] push_regs;
  pr_id_t [SS-1:0] free_list_regs;
  logic            avail;
  fl_cnt_t         count;
  logic            err_underflow;
  logic            err_overflow;

  always #5 clk = ~clk;

  free_list dut (
    .clk            (clk),
    .rst            (rst),
    .pop            (pop),
    .free_list_regs (free_list_regs),
    .avail          (avail),
    .push_valid     (push_valid),
    .push_regs      (push_regs),
    .count          (count),
    .err_underflow  (err_underflow),
    .err_overflow   (err_overflow)
  );

  typedef struct {
    int              cnt;
    logic            avail;
    logic            eu;
    logic            eo;
    pr_id_t [SS-1:0] regs;
  } exp_t;

  exp_t exp_q[$];
  int   fl[$];        // free IDs, head first
  bit   m_eu, m_eo;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input bit r, input bit p, input logic [SS-1:0] v,
                      input pr_id_t [SS-1:0] ids);
    exp_t e;
    int   cnt, n;
    bit   pok;
    rst = r; pop = p; push_valid = v; push_regs = ids;
    if (r) begin
      fl.delete();
      for (int i = 0; i < FL_DEPTH; i++) fl.push_back(ARCH_REGS + i);
      m_eu = 0; m_eo = 0;
    end else begin
      cnt = fl.size();
      pok = p && (cnt >= SS);
      if (p && !pok) m_eu = 1;
      n = 0;
      for (int i = 0; i < SS; i++) if (v[i]) n++;
      if (cnt - (pok ? SS : 0) + n > FL_DEPTH) begin
        m_eo = 1;
      end else begin
        for (int i = 0; i < SS; i++) if (v[i]) fl.push_back(int'(ids[i]));
      end
      if (pok) for (int i = 0; i < SS; i++) void'(fl.pop_front());
    end
    e.cnt   = fl.size();
    e.avail = (fl.size() >= SS);
    e.eu    = m_eu;
    e.eo    = m_eo;
    e.regs  = '0;
    for (int i = 0; i < SS; i++) if (i < fl.size()) e.regs[i] = pr_id_t'(fl[i]);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation per edge, compared after outputs settle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", int'(count), e.cnt);
        chk("avail", int'(avail), int'(e.avail));
        chk("err_underflow", int'(err_underflow), int'(e.eu));
        chk("err_overflow", int'(err_overflow), int'(e.eo));
        for (int i = 0; i < SS; i++) begin
          if (i < e.cnt) chk($sformatf("free_list_regs[%0d]", i),
                             int'(free_list_regs[i]), int'(e.regs[i]));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    pr_id_t [SS-1:0] ids;
    logic [SS-1:0]   v;
    bit              p, r;
    rst = 1'b1; pop = 1'b0; push_valid = '0; push_regs = '0;
    ids = '0;
    @(negedge clk);

    // Reset, then a single pop: {32,33} -> {34,35}, count 30.
    step(1, 0, '0, ids);
    step(1, 0, '0, ids);
    step(0, 1, '0, ids);
    // Drain to empty, then an underflowing pop.
    repeat (15) step(0, 1, '0, ids);
    step(0, 1, '0, ids);
    step(0, 0, '0, ids);
    // Push {5,9} while popping at count 0: pop ignored.
    ids = {pr_id_t'(9), pr_id_t'(5)};
    step(0, 1, 2'b11, ids);
    // Pop both while lane 1 alone returns 12: compaction puts it at tail+0.
    ids = {pr_id_t'(12), pr_id_t'(0)};
    step(0, 1, 2'b10, ids);
    step(0, 0, '0, ids);

    // Overflow at full without pop: dropped.
    step(1, 0, '0, ids);
    ids = {pr_id_t'(0), pr_id_t'(7)};
    step(0, 0, 2'b01, ids);
    // Same push with pop: fits, count 31, no error.
    step(1, 0, '0, ids);
    step(0, 1, 2'b01, ids);
    step(0, 0, '0, ids);

    // Randomized traffic with occasional mid-operation reset.
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(255, 0) == 0);
      p = $urandom_range(1, 0) == 1;
      v = SS'($urandom());
      for (int i = 0; i < SS; i++) ids[i] = pr_id_t'($urandom_range(PR_ENTRIES - 1, 0));
      step(r, p, v, ids);
    end
    step(0, 0, '0, ids);
    step(0, 0, '0, ids);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
